// File: rtl/food_spawner.sv
// food_spawner: turns free-running 7-bit random X/Y samples into a legal food
// cell on the playfield. Each candidate is folded into grid range, then the
// snake body RAM is scanned (registered read) to reject positions that sit
// on the snake. A rejected candidate is resampled up to MAX_TRIES times.
//
// Optional build macro FOOD_BORDER_GUARD_EN: when defined, candidates on a
// border cell are rejected in SAMPLE without a scan (one try, one cycle).
module food_spawner #(
    parameter int GRID_W    = 96,
    parameter int GRID_H    = 64,
    parameter int MAX_LEN   = 64,
    parameter int ADDR_W    = 6,
    parameter int MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spawn_req,
    input  logic              food_clear,
    input  logic [6:0]        rand_x,
    input  logic [6:0]        rand_y,
    input  logic [6:0]        snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [6:0]        seg_x,
    input  logic [6:0]        seg_y,
    output logic [6:0]        food_x,
    output logic [6:0]        food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              spawn_done,
    output logic              spawn_fail
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [6:0] GW7 = 7'(GRID_W);
    localparam logic [6:0] GH7 = 7'(GRID_H);
    localparam logic [6:0] ML7 = 7'(MAX_LEN);
    localparam logic [TRY_W-1:0] MAXT = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SCAN,
        S_COMMIT,
        S_FAIL
    } state_t;

    state_t state_reg, state_next;

    logic [6:0]        cx_reg, cx_next;
    logic [6:0]        cy_reg, cy_next;
    logic [TRY_W-1:0]  try_reg, try_next;
    logic [6:0]        scan_reg, scan_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              hit_reg, hit_next;
    logic [6:0]        food_x_reg, food_x_next;
    logic [6:0]        food_y_reg, food_y_next;
    logic              food_valid_reg, food_valid_next;

    logic [6:0]        fold_x, fold_y, eff_len;
    logic [TRY_W-1:0]  try_plus;
    logic              seg_match, border, final_hit;

    // Fold the raw samples into grid range and derive the scan length.
    always_comb begin
        fold_x   = (rand_x >= GW7) ? (rand_x - GW7) : rand_x;
        fold_y   = (rand_y >= GH7) ? (rand_y - GH7) : rand_y;
        eff_len  = (snake_len > ML7) ? ML7 : snake_len;
        try_plus = try_reg + TRY_W'(1);
        // RAM data in scan step j belongs to address j-1, so step 0 has no data.
        seg_match = (scan_reg != 7'd0) && (seg_x == cx_reg) && (seg_y == cy_reg);
        final_hit = hit_reg | seg_match;
`ifdef FOOD_BORDER_GUARD_EN
        border = (fold_x == 7'd0) || (fold_x == GW7 - 7'd1) ||
                 (fold_y == 7'd0) || (fold_y == GH7 - 7'd1);
`else
        border = 1'b0;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cx_reg         <= '0;
            cy_reg         <= '0;
            try_reg        <= '0;
            scan_reg       <= '0;
            addr_reg       <= '0;
            hit_reg        <= 1'b0;
            food_x_reg     <= '0;
            food_y_reg     <= '0;
            food_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cx_reg         <= cx_next;
            cy_reg         <= cy_next;
            try_reg        <= try_next;
            scan_reg       <= scan_next;
            addr_reg       <= addr_next;
            hit_reg        <= hit_next;
            food_x_reg     <= food_x_next;
            food_y_reg     <= food_y_next;
            food_valid_reg <= food_valid_next;
        end
    end

    // Next-state logic, scan sequencing and output pulses.
    always_comb begin
        state_next      = state_reg;
        cx_next         = cx_reg;
        cy_next         = cy_reg;
        try_next        = try_reg;
        scan_next       = scan_reg;
        addr_next       = addr_reg;
        hit_next        = hit_reg;
        food_x_next     = food_x_reg;
        food_y_next     = food_y_reg;
        food_valid_next = food_clear ? 1'b0 : food_valid_reg;
        spawn_done      = 1'b0;
        spawn_fail      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (spawn_req) begin
                    state_next = S_SAMPLE;
                    try_next   = '0;
                    addr_next  = '0;
                end
            end
            S_SAMPLE: begin
                cx_next   = fold_x;
                cy_next   = fold_y;
                try_next  = try_plus;
                hit_next  = 1'b0;
                scan_next = '0;
                addr_next = '0;
                if (border) begin
                    state_next = (try_plus >= MAXT) ? S_FAIL : S_SAMPLE;
                end else begin
                    // An empty body still spends one SCAN cycle, which keeps
                    // first-try latency at L+3 for every L.
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (seg_match) begin
                    hit_next = 1'b1;
                end
                if (scan_reg == eff_len) begin
                    if (!final_hit) begin
                        state_next = S_COMMIT;
                    end else if (try_reg < MAXT) begin
                        state_next = S_SAMPLE;
                    end else begin
                        state_next = S_FAIL;
                    end
                end else begin
                    scan_next = scan_reg + 7'd1;
                    // Stop advancing at the tail so stale entries are never read.
                    if ((scan_reg + 7'd1) < eff_len) begin
                        addr_next = ADDR_W'(scan_reg + 7'd1);
                    end
                end
            end
            S_COMMIT: begin
                food_x_next     = cx_reg;
                food_y_next     = cy_reg;
                food_valid_next = 1'b1;
                spawn_done      = 1'b1;
                state_next      = S_IDLE;
            end
            S_FAIL: begin
                spawn_fail = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign seg_addr   = addr_reg;
    assign food_x     = food_x_reg;
    assign food_y     = food_y_reg;
    assign food_valid = food_valid_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: random and directed spawn requests checked against a
// cycle-level outcome model computed from the placement rules.
module tb_food_spawner;

    localparam int GW   = 96;
    localparam int GH   = 64;
    localparam int MAXT = 16;
    localparam int NH   = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       spawn_req;
    logic       food_clear;
    logic [6:0] rand_x, rand_y, snake_len;
    logic [5:0] seg_addr;
    logic [6:0] seg_x, seg_y;
    logic [6:0] food_x, food_y;
    logic       food_valid, busy, spawn_done, spawn_fail;

    always #5 clk = ~clk;

    food_spawner dut (
        .clk        (clk),
        .rst        (rst),
        .spawn_req  (spawn_req),
        .food_clear (food_clear),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .spawn_done (spawn_done),
        .spawn_fail (spawn_fail)
    );

    // Body RAM with registered read.
    logic [6:0] mem_x [64];
    logic [6:0] mem_y [64];
    always @(posedge clk) begin
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    int checks   = 0;
    int failures = 0;
    int rx [NH];
    int ry [NH];
    int exp_fx = 0, exp_fy = 0, exp_valid = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fold(input int v, input int g);
        return (v >= g) ? v - g : v;
    endfunction

    function automatic bit on_border(input int x, input int y);
`ifdef FOOD_BORDER_GUARD_EN
        return (x == 0) || (x == GW - 1) || (y == 0) || (y == GH - 1);
`else
        return (x < 0) || (y < 0);
`endif
    endfunction

    // Outcome model: which try succeeds and in which cycle (cycle 1 is the
    // one after the edge that sampled spawn_req). Try t samples the random
    // value present in its cycle; a scan costs L+1 cycles after the sample.
    task automatic predict(input int len, output int end_cyc, output bit ok,
                           output int fx, output int fy);
        int k;
        int cx, cy;
        bit hit;
        k = 1; ok = 0; fx = 0; fy = 0; end_cyc = 0;
        for (int t = 1; t <= MAXT; t++) begin
            cx = fold(rx[k], GW);
            cy = fold(ry[k], GH);
            if (on_border(cx, cy)) begin
                if (t == MAXT) begin end_cyc = k + 1; return; end
                k = k + 1;
            end else begin
                hit = 0;
                for (int i = 0; i < len; i++)
                    if (int'(mem_x[i]) == cx && int'(mem_y[i]) == cy) hit = 1;
                if (!hit) begin
                    ok = 1; fx = cx; fy = cy; end_cyc = k + len + 2; return;
                end
                if (t == MAXT) begin end_cyc = k + len + 2; return; end
                k = k + len + 2;
            end
        end
    endtask

    task automatic fill_const(input int x, input int y);
        for (int c = 0; c < NH; c++) begin rx[c] = x; ry[c] = y; end
    endtask

    // Random body plus candidate stream biased towards body and tail cells.
    task automatic fill_random(input int len);
        int r, i, x, y;
        for (int j = 0; j < 64; j++) begin
            mem_x[j] = 7'($urandom_range(0, GW - 1));
            mem_y[j] = 7'($urandom_range(0, GH - 1));
        end
        for (int c = 0; c < NH; c++) begin
            r = $urandom_range(0, 3);
            if (r < 2 && len > 0) begin
                i = $urandom_range(0, len - 1);
            end else if (r == 2 && len < 64) begin
                i = $urandom_range(len, 63);
            end else begin
                i = -1;
            end
            if (i >= 0) begin
                x = int'(mem_x[i]); y = int'(mem_y[i]);
                if ($urandom_range(0, 1) == 1 && x + GW <= 127) x = x + GW;
                if ($urandom_range(0, 1) == 1 && y + GH <= 127) y = y + GH;
            end else begin
                x = $urandom_range(0, 127); y = $urandom_range(0, 127);
            end
            rx[c] = x; ry[c] = y;
        end
    endtask

    task automatic run_spawn(input string tag, input int slen,
                             input bit extra_req, input bit clear_commit);
        int len, end_cyc, fx, fy, got_cyc, pulses, got_ok;
        bit ok;
        len = (slen > 64) ? 64 : slen;
        predict(len, end_cyc, ok, fx, fy);
        got_cyc = 0; pulses = 0; got_ok = 0;
        @(negedge clk);
        snake_len = 7'(slen);
        spawn_req = 1'b1;
        rand_x = 7'(rx[0]); rand_y = 7'(ry[0]);
        for (int c = 1; c <= end_cyc + 2; c++) begin
            @(negedge clk);
            spawn_req  = extra_req && (c == 2);
            food_clear = clear_commit && (c == end_cyc);
            rand_x = 7'(rx[c]); rand_y = 7'(ry[c]);
            if (busy && len > 0) check({tag, "_tail"}, int'(seg_addr) < len, 1);
            if (spawn_done || spawn_fail) begin
                pulses++;
                if (got_cyc == 0) begin got_cyc = c; got_ok = int'(spawn_done); end
            end
            if (c == end_cyc + 1) check({tag, "_busy_after"}, int'(busy), 0);
        end
        food_clear = 1'b0;
        if (ok) begin exp_fx = fx; exp_fy = fy; exp_valid = 1; end
        else if (clear_commit) exp_valid = 0;
        check({tag, "_cycle"}, got_cyc, end_cyc);
        check({tag, "_ok"}, got_ok, int'(ok));
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_fx"}, int'(food_x), exp_fx);
        check({tag, "_fy"}, int'(food_y), exp_fy);
        check({tag, "_valid"}, int'(food_valid), exp_valid);
        $display("txn %s len=%0d ok=%0d cycle=%0d food=(%0d,%0d)",
                 tag, len, ok, got_cyc, food_x, food_y);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int slen, pulses;
        rst = 1'b1; spawn_req = 1'b0; food_clear = 1'b0;
        rand_x = '0; rand_y = '0; snake_len = '0;
        for (int j = 0; j < 64; j++) begin mem_x[j] = '0; mem_y[j] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_fx", int'(food_x), 0);
        check("rst_fy", int'(food_y), 0);
        check("rst_valid", int'(food_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(spawn_done), 0);
        check("rst_fail", int'(spawn_fail), 0);
        check("rst_addr", int'(seg_addr), 0);

        // Empty snake, plain sample.
        fill_const(10, 20);
        run_spawn("len0", 0, 0, 0);

        // Fold boundaries.
        fill_const(96, 64);
        run_spawn("fold_edge", 0, 0, 0);
        fill_const(127, 100);
        run_spawn("fold_max", 0, 0, 0);

        // First sample collides with segment 3, second lands on a stale tail cell.
        mem_x[0] = 7'd1; mem_y[0] = 7'd1;
        mem_x[1] = 7'd2; mem_y[1] = 7'd2;
        mem_x[2] = 7'd3; mem_y[2] = 7'd3;
        mem_x[3] = 7'd10; mem_y[3] = 7'd20;
        mem_x[4] = 7'd5; mem_y[4] = 7'd5;
        fill_const(10, 20);
        rx[7] = 5; ry[7] = 5;
        run_spawn("retry", 4, 0, 0);

        // Every sample collides: fail, food unchanged.
        mem_x[0] = 7'd10; mem_y[0] = 7'd20;
        mem_x[1] = 7'd30; mem_y[1] = 7'd30;
        fill_const(10, 20);
        run_spawn("exhaust", 2, 0, 0);

        // Extra request mid-scan plus food_clear in the commit cycle.
        fill_const(40, 30);
        run_spawn("busy_req", 3, 1, 1);

        // food_clear in IDLE.
        @(negedge clk);
        food_clear = 1'b1;
        @(negedge clk);
        food_clear = 1'b0;
        exp_valid = 0;
        check("clear_idle", int'(food_valid), 0);
        $display("txn clear_idle valid=%0d", food_valid);

        // Reset in the middle of a scan.
        fill_random(8);
        pulses = 0;
        @(negedge clk);
        snake_len = 7'd8; spawn_req = 1'b1; rand_x = 7'd50; rand_y = 7'd40;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            spawn_req = 1'b0;
            if (spawn_done || spawn_fail) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (spawn_done || spawn_fail) pulses++;
        exp_fx = 0; exp_fy = 0; exp_valid = 0;
        check("rstscan_pulses", pulses, 0);
        check("rstscan_busy", int'(busy), 0);
        check("rstscan_valid", int'(food_valid), 0);
        check("rstscan_fx", int'(food_x), 0);
        check("rstscan_addr", int'(seg_addr), 0);
        $display("txn reset_mid_scan busy=%0d valid=%0d", busy, food_valid);
        run_spawn("after_rst", 8, 0, 0);

        // Random traffic.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 7))
                0:       slen = 64;
                1:       slen = 100;
                default: slen = $urandom_range(0, 12);
            endcase
            fill_random(slen > 64 ? 64 : slen);
            run_spawn($sformatf("rnd%0d", n), slen,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
